// File: rtl/packet_store_fifo.sv
// Stores rx frames in a circular RAM, commits good frame lengths to a length FIFO and rolls bad frames back.
// Read data follows ird_en by one cycle; the rx side is never stalled: frames that do not fit are dropped and counted.
module packet_store_fifo #(
  parameter int pDATA_WIDTH     = 8,
  parameter int pDEPTH_RAM      = 4096,
  parameter int pLEN_DEPTH      = 64,
  parameter int pLEN_WIDTH      = 16,
  parameter int pMAX_PACKET_LEN = 1536,
  parameter int pMIN_PACKET_LEN = 64
) (
  input  logic                            iclk,
  input  logic                            i_rst,
  input  logic                            idv,
  input  logic [pDATA_WIDTH-1:0]          irx_d,
  input  logic                            irx_er,
  input  logic                            ird_en,
  input  logic                            iskip,
  output logic                            opkt_avail,
  output logic [pLEN_WIDTH-1:0]           olen_pac,
  output logic [pDATA_WIDTH-1:0]          or_data,
  output logic                            or_valid,
  output logic                            olast,
  output logic                            ofull,
  output logic                            oempty,
  output logic [$clog2(pDEPTH_RAM+1)-1:0] ofree_words,
  output logic [15:0]                     odrop_cnt
);
  localparam int AW  = $clog2(pDEPTH_RAM);
  localparam int FW  = $clog2(pDEPTH_RAM + 1);
  localparam int SW  = ((AW > pLEN_WIDTH) ? AW : pLEN_WIDTH) + 1;
  localparam int LPW = (pLEN_DEPTH > 1) ? $clog2(pLEN_DEPTH) : 1;
  localparam int LCW = $clog2(pLEN_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DISCARD} state_t;

  state_t                 r_state, w_state_nxt;
  logic [pDATA_WIDTH-1:0] r_mem [pDEPTH_RAM];
  logic [pLEN_WIDTH-1:0]  r_len_mem [pLEN_DEPTH];
  logic [AW-1:0]          r_wr_succ, r_wr_now, r_rd_ptr;
  logic [pLEN_WIDTH-1:0]  r_cnt, r_rd_off;
  logic [FW-1:0]          r_occ, r_free;
  logic [LPW-1:0]         r_len_wr, r_len_rd;
  logic [LCW-1:0]         r_len_cnt;
  logic [pDATA_WIDTH-1:0] r_or_data;
  logic                   r_or_valid, r_olast, r_full;
  logic [15:0]            r_drop;

  logic                   w_wr, w_commit, w_rollback, w_drop;
  logic                   w_len_empty, w_len_full, w_ram_full, w_cnt_max, w_accept_first;
  logic                   w_rd, w_skip, w_last, w_pop;
  logic [pLEN_WIDTH-1:0]  w_head_len, w_rem, w_cnt_nxt;
  logic [SW-1:0]          w_sum;
  logic [AW-1:0]          w_skip_ptr;
  logic [FW-1:0]          w_rd_words, w_occ_nxt, w_free_nxt;
  logic [LCW-1:0]         w_len_cnt_nxt;

  function automatic logic [AW-1:0] f_ram_inc(input logic [AW-1:0] p);
    return (p == AW'(pDEPTH_RAM - 1)) ? '0 : p + AW'(1);
  endfunction

  function automatic logic [LPW-1:0] f_len_inc(input logic [LPW-1:0] p);
    return (p == LPW'(pLEN_DEPTH - 1)) ? '0 : p + LPW'(1);
  endfunction

  assign w_len_empty    = (r_len_cnt == '0);
  assign w_len_full     = (r_len_cnt == LCW'(pLEN_DEPTH));
  assign w_ram_full     = (r_free == '0);
  assign w_cnt_max      = (r_cnt == pLEN_WIDTH'(pMAX_PACKET_LEN));
  assign w_accept_first = !irx_er && !w_len_full && !w_ram_full;

  always_ff @(posedge iclk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (idv) w_state_nxt = w_accept_first ? S_WRITE : S_DISCARD;
      S_WRITE: begin
        if (idv) begin
          if (irx_er || w_cnt_max || w_ram_full) w_state_nxt = S_DISCARD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DISCARD: if (!idv) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Every entry into DISCARD and every runt rollback counts as one drop.
  always_comb begin
    w_wr       = 1'b0;
    w_commit   = 1'b0;
    w_rollback = 1'b0;
    w_drop     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_wr   = idv && w_accept_first;
        w_drop = idv && !w_accept_first;
      end
      S_WRITE: begin
        if (idv) begin
          if (irx_er || w_cnt_max || w_ram_full) begin
            w_rollback = 1'b1;
            w_drop     = 1'b1;
          end else begin
            w_wr = 1'b1;
          end
        end else if (r_cnt >= pLEN_WIDTH'(pMIN_PACKET_LEN)) begin
          w_commit = 1'b1;
        end else begin
          w_rollback = 1'b1;
          w_drop     = 1'b1;
        end
      end
      S_DISCARD: ;
      default:   ;
    endcase
  end

  assign w_head_len = r_len_mem[r_len_rd];
  assign w_rem      = w_head_len - r_rd_off;
  assign w_skip     = iskip && !w_len_empty;
  assign w_rd       = ird_en && !w_len_empty && !iskip;
  assign w_last     = w_rd && (r_rd_off == w_head_len - pLEN_WIDTH'(1));
  assign w_pop      = w_skip || w_last;
  assign w_sum      = SW'(r_rd_ptr) + SW'(w_rem);
  assign w_skip_ptr = (w_sum >= SW'(pDEPTH_RAM)) ? AW'(w_sum - SW'(pDEPTH_RAM)) : AW'(w_sum);

  assign w_rd_words = w_skip ? FW'(w_rem) : (w_rd ? FW'(1) : FW'(0));
  assign w_occ_nxt  = r_occ + (w_commit ? FW'(r_cnt) : FW'(0)) - w_rd_words;
  assign w_cnt_nxt  = (w_commit || w_rollback) ? '0 : (w_wr ? r_cnt + pLEN_WIDTH'(1) : r_cnt);
  assign w_free_nxt = FW'(pDEPTH_RAM) - w_occ_nxt - FW'(w_cnt_nxt);

  always_comb begin
    w_len_cnt_nxt = r_len_cnt;
    case ({w_commit, w_pop})
      2'b10:   w_len_cnt_nxt = r_len_cnt + LCW'(1);
      2'b01:   w_len_cnt_nxt = r_len_cnt - LCW'(1);
      default: w_len_cnt_nxt = r_len_cnt;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (w_wr) r_mem[r_wr_now] <= irx_d;
  end

  always_ff @(posedge iclk) begin
    if (w_commit) r_len_mem[r_len_wr] <= r_cnt;
  end

  always_ff @(posedge iclk) begin
    if (i_rst) begin
      r_wr_succ  <= '0;
      r_wr_now   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_rd_off   <= '0;
      r_occ      <= '0;
      r_free     <= FW'(pDEPTH_RAM);
      r_full     <= 1'b0;
      r_len_wr   <= '0;
      r_len_rd   <= '0;
      r_len_cnt  <= '0;
      r_or_data  <= '0;
      r_or_valid <= 1'b0;
      r_olast    <= 1'b0;
      r_drop     <= '0;
    end else begin
      if (w_wr)            r_wr_now <= f_ram_inc(r_wr_now);
      else if (w_rollback) r_wr_now <= r_wr_succ;
      if (w_commit) begin
        r_wr_succ <= r_wr_now;
        r_len_wr  <= f_len_inc(r_len_wr);
      end
      r_cnt     <= w_cnt_nxt;
      r_occ     <= w_occ_nxt;
      r_free    <= w_free_nxt;
      r_len_cnt <= w_len_cnt_nxt;
      r_full    <= (w_len_cnt_nxt == LCW'(pLEN_DEPTH)) || (int'(w_free_nxt) < pMAX_PACKET_LEN);
      if (w_pop) r_len_rd <= f_len_inc(r_len_rd);
      if (w_skip) begin
        r_rd_ptr <= w_skip_ptr;
        r_rd_off <= '0;
      end else if (w_rd) begin
        r_rd_ptr  <= f_ram_inc(r_rd_ptr);
        r_rd_off  <= w_last ? '0 : r_rd_off + pLEN_WIDTH'(1);
        r_or_data <= r_mem[r_rd_ptr];
      end
      r_or_valid <= w_rd;
      r_olast    <= w_last;
      if (w_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
    end
  end

  assign opkt_avail  = !w_len_empty;
  assign oempty      = w_len_empty;
  assign olen_pac    = w_len_empty ? '0 : w_head_len;
  assign or_data     = r_or_data;
  assign or_valid    = r_or_valid;
  assign olast       = r_olast;
  assign ofull       = r_full;
  assign ofree_words = r_free;
  assign odrop_cnt   = r_drop;
endmodule

// File: tb/tb_packet_store_fifo.sv
// Bench for packet_store_fifo: three instances (default, 200-word RAM, 2-entry length FIFO) share stimulus.
module tb_packet_store_fifo;
  logic       iclk = 1'b0;
  logic       i_rst = 1'b1;
  logic       idv = 1'b0, irx_er = 1'b0, ird_en = 1'b0, iskip = 1'b0;
  logic [7:0] irx_d = '0;

  logic        a_avail, a_valid, a_last, a_full, a_empty;
  logic [15:0] a_len, a_drop;
  logic [7:0]  a_data;
  logic [12:0] a_free;
  logic        b_avail, b_valid, b_last, b_full, b_empty;
  logic [15:0] b_len, b_drop;
  logic [7:0]  b_data;
  logic [7:0]  b_free;
  logic        c_avail, c_valid, c_last, c_full, c_empty;
  logic [15:0] c_len, c_drop;
  logic [7:0]  c_data;
  logic [12:0] c_free;

  always #5 iclk = ~iclk;

  packet_store_fifo u_a (
    .iclk(iclk), .i_rst(i_rst), .idv(idv), .irx_d(irx_d), .irx_er(irx_er), .ird_en(ird_en), .iskip(iskip),
    .opkt_avail(a_avail), .olen_pac(a_len), .or_data(a_data), .or_valid(a_valid), .olast(a_last),
    .ofull(a_full), .oempty(a_empty), .ofree_words(a_free), .odrop_cnt(a_drop));

  packet_store_fifo #(.pDEPTH_RAM(200), .pLEN_DEPTH(4)) u_b (
    .iclk(iclk), .i_rst(i_rst), .idv(idv), .irx_d(irx_d), .irx_er(irx_er), .ird_en(ird_en), .iskip(iskip),
    .opkt_avail(b_avail), .olen_pac(b_len), .or_data(b_data), .or_valid(b_valid), .olast(b_last),
    .ofull(b_full), .oempty(b_empty), .ofree_words(b_free), .odrop_cnt(b_drop));

  packet_store_fifo #(.pLEN_DEPTH(2)) u_c (
    .iclk(iclk), .i_rst(i_rst), .idv(idv), .irx_d(irx_d), .irx_er(irx_er), .ird_en(ird_en), .iskip(iskip),
    .opkt_avail(c_avail), .olen_pac(c_len), .or_data(c_data), .or_valid(c_valid), .olast(c_last),
    .ofull(c_full), .oempty(c_empty), .ofree_words(c_free), .odrop_cnt(c_drop));

  typedef struct {
    logic [7:0] d;
    bit         last;
  } exp_t;

  typedef struct {
    int len;
    int err_at;
    int exp_olen;
    int exp_drop;
    int exp_free;
  } vec_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   valid_cnt = 0;
  int   sel = 0;
  int   m_avail, m_empty, m_valid, m_last, m_full, m_len, m_data, m_free, m_drop;

  always_comb begin
    case (sel)
      1: begin
        m_avail = int'(b_avail); m_empty = int'(b_empty); m_valid = int'(b_valid); m_last = int'(b_last);
        m_full = int'(b_full); m_len = int'(b_len); m_data = int'(b_data); m_free = int'(b_free); m_drop = int'(b_drop);
      end
      2: begin
        m_avail = int'(c_avail); m_empty = int'(c_empty); m_valid = int'(c_valid); m_last = int'(c_last);
        m_full = int'(c_full); m_len = int'(c_len); m_data = int'(c_data); m_free = int'(c_free); m_drop = int'(c_drop);
      end
      default: begin
        m_avail = int'(a_avail); m_empty = int'(a_empty); m_valid = int'(a_valid); m_last = int'(a_last);
        m_full = int'(a_full); m_len = int'(a_len); m_data = int'(a_data); m_free = int'(a_free); m_drop = int'(a_drop);
      end
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every read word of the watched instance must match the next expected word.
  always @(negedge iclk) begin
    exp_t e;
    if (!i_rst && m_valid != 0) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL sb_extra: got data %0d, expected no read word", m_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", m_data, int'(e.d));
        chk("sb_last", m_last, int'(e.last));
      end
    end
  end

  task automatic do_reset();
    i_rst = 1'b1; idv = 1'b0; irx_er = 1'b0; ird_en = 1'b0; iskip = 1'b0;
    repeat (3) @(posedge iclk);
    #1;
    exp_q.delete();
    i_rst = 1'b0;
  endtask

  task automatic send_pkt(input int len, input int err_at, input int seed, input bit good);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      @(posedge iclk); #1;
      idv = 1'b1;
      irx_d = 8'((i + seed) & 255);
      irx_er = (i == err_at);
      if (good) begin
        e.d = irx_d;
        e.last = (i == len - 1);
        exp_q.push_back(e);
      end
    end
    @(posedge iclk); #1;
    idv = 1'b0; irx_er = 1'b0;
    repeat (3) @(posedge iclk);
    #1;
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge iclk); #1;
      ird_en = 1'b1;
    end
    @(posedge iclk); #1;
    ird_en = 1'b0;
    repeat (3) @(posedge iclk);
    #1;
  endtask

  initial begin
    vec_t tbl [7];
    exp_t e;
    tbl[0] = '{64,   -1, 64,   0, 4032};
    tbl[1] = '{100,  50, 0,    1, 4096};
    tbl[2] = '{63,   -1, 0,    2, 4096};
    tbl[3] = '{1537, -1, 0,    3, 4096};
    tbl[4] = '{1536, -1, 1536, 3, 2560};
    tbl[5] = '{65,   64, 0,    4, 4096};
    tbl[6] = '{70,    0, 0,    5, 4096};

    // Reset state
    sel = 0;
    do_reset();
    chk("rst_avail", m_avail, 0);
    chk("rst_empty", m_empty, 1);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_len", m_len, 0);
    chk("rst_full", m_full, 0);
    chk("rst_free", m_free, 4096);
    chk("rst_drop", m_drop, 0);
    chk("rst_free_b", int'(b_free), 200);

    // Single-packet table on the default instance
    for (int r = 0; r < 7; r++) begin
      send_pkt(tbl[r].len, tbl[r].err_at, r * 29, tbl[r].exp_olen != 0);
      chk($sformatf("v%0d_avail", r), m_avail, int'(tbl[r].exp_olen != 0));
      chk($sformatf("v%0d_len", r), m_len, tbl[r].exp_olen);
      chk($sformatf("v%0d_drop", r), m_drop, tbl[r].exp_drop);
      chk($sformatf("v%0d_free", r), m_free, tbl[r].exp_free);
      chk($sformatf("v%0d_full", r), m_full, 0);
      if (tbl[r].exp_olen != 0) begin
        read_n(tbl[r].len);
        chk($sformatf("v%0d_empty_after", r), m_empty, 1);
        chk($sformatf("v%0d_free_after", r), m_free, 4096);
      end
    end
    chk("sb_drain_a", exp_q.size(), 0);

    // Skip mid-packet, then back-to-back read across a packet boundary
    do_reset();
    send_pkt(64, -1, 7, 1'b1);
    send_pkt(70, -1, 50, 1'b1);
    send_pkt(80, -1, 90, 1'b1);
    chk("skip_len0", m_len, 64);
    chk("skip_free0", m_free, 4096 - 214);
    read_n(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.last) break;
    end
    @(posedge iclk); #1;
    iskip = 1'b1; ird_en = 1'b1;
    @(posedge iclk); #1;
    iskip = 1'b0; ird_en = 1'b0;
    chk("skip_len1", m_len, 70);
    chk("skip_free1", m_free, 4096 - 150);
    valid_cnt = 0;
    read_n(150);
    chk("b2b_valid_cnt", valid_cnt, 150);
    chk("b2b_empty", m_empty, 1);
    chk("b2b_free", m_free, 4096);
    @(posedge iclk); #1;
    ird_en = 1'b1;
    @(posedge iclk); #1;
    ird_en = 1'b0;
    chk("rd_on_empty", m_valid, 0);
    iskip = 1'b1;
    @(posedge iclk); #1;
    iskip = 1'b0;
    @(posedge iclk); #1;
    chk("skip_on_empty_free", m_free, 4096);
    chk("skip_on_empty_empty", m_empty, 1);
    chk("sb_drain_skip", exp_q.size(), 0);

    // 200-word RAM: overflow drop, then a wrapped packet
    sel = 1;
    do_reset();
    send_pkt(64, -1, 200, 1'b1);
    send_pkt(64, -1, 210, 1'b1);
    send_pkt(100, -1, 220, 1'b0);
    chk("ovf_drop", m_drop, 1);
    chk("ovf_free", m_free, 72);
    chk("ovf_len", m_len, 64);
    read_n(64);
    chk("ovf_free_rd", m_free, 136);
    send_pkt(100, -1, 230, 1'b1);
    chk("wrap_free", m_free, 36);
    chk("wrap_drop", m_drop, 1);
    read_n(164);
    chk("wrap_empty", m_empty, 1);
    chk("wrap_free_end", m_free, 200);
    chk("sb_drain_b", exp_q.size(), 0);

    // 2-entry length FIFO: full drop, then recovery
    sel = 2;
    do_reset();
    send_pkt(64, -1, 100, 1'b1);
    send_pkt(66, -1, 120, 1'b1);
    chk("lf_full", m_full, 1);
    send_pkt(68, -1, 160, 1'b0);
    chk("lf_drop", m_drop, 1);
    chk("lf_full2", m_full, 1);
    read_n(64);
    chk("lf_full_rd", m_full, 0);
    chk("lf_len_rd", m_len, 66);
    send_pkt(70, -1, 140, 1'b1);
    chk("lf_len_new", m_len, 66);
    chk("lf_drop_new", m_drop, 1);
    read_n(136);
    chk("lf_empty", m_empty, 1);
    chk("sb_drain_c", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/packet_store_fifo.md
Name: packet_store_fifo

Overview:
Parametrised successor to the single-channel packet-to-memory copier. Stores received frames (byte/word stream qualified by idv) into a circular SRAM and commits each good frame's length into a length FIFO. Bad frames are rolled back without consuming space: rx error, runt, oversize, RAM overflow, or length-FIFO full. The read side presents whole committed packets with a length-first interface, last-word flag and a skip (discard-head) command. It sits between the MAC rx frame decoder and the forwarding/copy logic.

Parameters:
pDATA_WIDTH, 8, width of irx_d / or_data (one "word" per idv cycle)
pDEPTH_RAM, 4096, SRAM depth in words; need not be a power of two
pLEN_DEPTH, 64, length-FIFO entries (max committed packets held)
pLEN_WIDTH, 16, width of length field
pMAX_PACKET_LEN, 1536, max accepted packet length in words
pMIN_PACKET_LEN, 64, min accepted packet length in words

Ports:
iclk  in  1  clock, all logic on rising edge
i_rst  in  1  synchronous reset, active-high
idv  in  1  rx word valid; contiguous high run = one packet
irx_d  in  pDATA_WIDTH  rx word
irx_er  in  1  rx error, sampled while idv high
ird_en  in  1  read one word of head packet
iskip  in  1  pulse: discard remaining words of head packet
opkt_avail  out  1  at least one committed packet stored
olen_pac  out  pLEN_WIDTH  length of head packet (valid when opkt_avail)
or_data  out  pDATA_WIDTH  read word
or_valid  out  1  or_data valid
olast  out  1  or_data is last word of its packet
ofull  out  1  length FIFO full OR free words < pMAX_PACKET_LEN
oempty  out  1  no committed packets (= !opkt_avail)
ofree_words  out  $clog2(pDEPTH_RAM+1)  pDEPTH_RAM - committed occupancy - words of packet in progress
odrop_cnt  out  16  dropped-packet counter, saturates at 16'hFFFF

Behaviour:
- Reset: write FSM IDLE; all pointers, counters 0; length FIFO empty. Outputs: opkt_avail=0, oempty=1, or_valid=0, olast=0, or_data=0, olen_pac=0, ofull=0, ofree_words=pDEPTH_RAM, odrop_cnt=0. Reset mid-packet abandons it (not counted as drop).
- Pointer width $clog2(pDEPTH_RAM). Increment rule: ptr+1==pDEPTH_RAM -> 0, else ptr+1. Skip advance: (ptr+n) mod pDEPTH_RAM via a single conditional subtract.
- Write FSM IDLE: on idv & !irx_er & !lenfifo_full & free>0 -> write irx_d at wr_succ, wr_now=wr_succ+1, count=1, go WRITE. On idv with any of those blocked -> go DISCARD.
- WRITE, idv & !irx_er: if count==pMAX_PACKET_LEN or free==0 -> rollback (wr_now=wr_succ), go DISCARD; else write at wr_now, advance, count++.
- WRITE, idv & irx_er -> rollback, go DISCARD.
- WRITE, !idv: if count>=pMIN_PACKET_LEN -> push count into length FIFO, wr_succ=wr_now, go IDLE (commit). Else rollback, odrop_cnt++, go IDLE.
- DISCARD: odrop_cnt++ once on entry; stay until idv low, then go IDLE. A new packet cannot start in the idv-low cycle.
- Read: head length loads a remaining counter when a packet becomes head. ird_en & opkt_avail at cycle t -> or_data/or_valid at t+1 (SRAM read latency 1). rd_ptr advances; remaining decrements.
- Last word: olast=1 with that or_data. The length FIFO is popped in cycle t; opkt_avail/olen_pac reflect the next packet at t+1. Back-to-back packets are readable with no bubble.
- ird_en while !opkt_avail is ignored: or_valid=0, no state change.
- iskip & opkt_avail: rd_ptr += remaining (wrap), pop, no or_valid. iskip beats ird_en in the same cycle. iskip while !opkt_avail is ignored.
- Simultaneous commit-push and read-pop in one cycle are both honoured. Count unchanged; committed occupancy = +committed len − words read.
- A commit into an empty FIFO makes opkt_avail 1 on the next cycle.
- Read-side word consumption frees space in the same cycle, visible in ofree_words next cycle.
- ofree_words, ofull are registered, updated every cycle.

Test Plan:
- Good 64-word packet (irx_d=0..63), then read: commit -> opkt_avail=1, olen_pac=64; 64 ird_en -> or_data 0..63 with 1-cycle latency; olast only on 63; oempty=1 after; odrop_cnt=0.
- 100-word packet with irx_er on word 50: rolled back, opkt_avail stays 0, ofree_words=pDEPTH_RAM, odrop_cnt=1.
- Runt of 63 words, then 1537-word packet: both dropped, odrop_cnt=2, no FIFO entries. A following 1536-word packet commits with olen_pac=1536.
- pDEPTH_RAM=200: two 64-word packets committed, third of 100 words -> overflow at word 73, dropped. Read first 64, then send 100 -> accepted with wrapped addresses; data read back intact.
- Three packets committed (lengths 64, 70, 80): iskip on first after reading 10 words -> head becomes 70; read it continuously with ird_en held -> olast then first word of 80-packet next cycle, no bubble.
- pLEN_DEPTH=2, two packets stored, third arrives -> DISCARD, odrop_cnt=1, ofull=1. Read one packet -> ofull=0; next packet commits.
